imem_load_rom: RTL and testbench

Parametrised, loadable instruction memory for the pipelined ARM core. It replaces the fixed combinational program ROM in front of the IF stage. After reset it accepts a program over a valid/ready load port, then switches to run mode and serves registered, one-cycle-latency fetches. It supports stalls and out-of-range fault reporting. Depth, word width and address width are parameters.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_ram.sv | 34 +++
 rtl/imem_load_rom.sv | 126 ++++++++++++
 tb/tb_imem_load_rom.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants, FSM state type and parity helper for the loadable instruction memory.
package imem_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_ADDR_W = 16;

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [DEF_DATA_W-1:0] NOP_WORD = '0;

   // Even parity over a zero-extended word; words up to 64 bits wide are covered.
   function automatic logic evenParity(input logic [63:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Word array with one synchronous write port and one registered, read-enabled read port.
module imem_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

   // The read register only moves on an enabled read, so the last word fetched stays put during stalls.
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_load_rom.sv
// Loadable instruction memory: program load over valid/ready, then registered one-cycle fetches.
// Optional feature macro: IMEM_PARITY_EN adds a stored even-parity bit and the parity_err output.
module imem_load_rom
   import imem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              run,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              addr_fault
`ifdef IMEM_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int RAM_W = DATA_W + PAR_W;
   localparam logic [AW-1:0]   LAST_IDX  = AW'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   state_e           state_q, state_d;
   logic [AW-1:0]    wptr_q, wptr_d;
   logic             loadFire, fetchFire, inRange, ramRe;
   logic [RAM_W-1:0] ramWdata, ramRdata;
   logic             valid_q, fault_q, useNop_q;

   assign load_ready = (state_q == LOAD);
   assign run        = (state_q == RUN);
   assign loadFire   = load_valid & load_ready;
   assign fetchFire  = run & fetch_en;
   assign inRange    = ({1'b0, fetch_addr} < DEPTH_EXT);
   assign ramRe      = fetchFire & inRange;

   // Writing the top slot forces RUN, so the pointer is held there rather than wrapping.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      if (loadFire) begin
         if (wptr_q != LAST_IDX) begin
            wptr_d = wptr_q + 1'b1;
         end
         if (load_last || (wptr_q == LAST_IDX)) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOAD;
         wptr_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
      end
   end

   // useNop_q selects the all-zero word after reset and after an out-of-range fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
         useNop_q <= 1'b1;
      end else begin
         valid_q <= fetchFire;
         if (fetchFire) begin
            fault_q  <= ~inRange;
            useNop_q <= ~inRange;
         end
      end
   end

`ifdef IMEM_PARITY_EN
   logic parChk_q;

   assign ramWdata = {evenParity(64'(load_data)), load_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         parChk_q <= 1'b0;
      end else if (fetchFire) begin
         parChk_q <= inRange;
      end
   end

   assign parity_err = parChk_q & (^ramRdata);
`else
   assign ramWdata = load_data;
`endif

   imem_ram #(
      .WIDTH (RAM_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) uRam (
      .clk     (clk),
      .we_i    (loadFire),
      .waddr_i (wptr_q),
      .wdata_i (ramWdata),
      .re_i    (ramRe),
      .raddr_i (fetch_addr[AW-1:0]),
      .rdata_o (ramRdata)
   );

   assign instr       = useNop_q ? DATA_W'(NOP_WORD) : ramRdata[DATA_W-1:0];
   assign instr_valid = valid_q;
   assign addr_fault  = fault_q;

endmodule

// File: tb/tb_imem_load_rom.sv
// Directed self-checking bench for imem_load_rom (default DEPTH=16, DATA_W=32, ADDR_W=16).
module tb_imem_load_rom;

   logic        clk;
   logic        reset;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic        run;
   logic        fetch_en;
   logic [15:0] fetch_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic        addr_fault;
`ifdef IMEM_PARITY_EN
   logic        parity_err;
`endif

   int assertCount = 0;
   int failCount   = 0;

   imem_load_rom dut (
      .clk         (clk),
      .reset       (reset),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_data   (load_data),
      .load_last   (load_last),
      .run         (run),
      .fetch_en    (fetch_en),
      .fetch_addr  (fetch_addr),
      .instr       (instr),
      .instr_valid (instr_valid),
      .addr_fault  (addr_fault)
`ifdef IMEM_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyLoad(input logic [31:0] data, input logic last);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic applyFetch(input logic [15:0] addr);
      fetch_en   = 1'b1;
      fetch_addr = addr;
      tick();
      fetch_en   = 1'b0;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      applyReset();
      assertCount++; if (run !== 1'b0)         begin failCount++; $display("[TB] FAIL reset_run: got %0b want 0", run); end
      assertCount++; if (load_ready !== 1'b1)  begin failCount++; $display("[TB] FAIL reset_load_ready: got %0b want 1", load_ready); end
      assertCount++; if (instr !== 32'h0)      begin failCount++; $display("[TB] FAIL reset_instr: got %h want 00000000", instr); end
      assertCount++; if (instr_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_instr_valid: got %0b want 0", instr_valid); end
      assertCount++; if (addr_fault !== 1'b0)  begin failCount++; $display("[TB] FAIL reset_addr_fault: got %0b want 0", addr_fault); end
   endtask

   // fetch_en is held high throughout the load to show it is ignored in LOAD.
   task automatic test_load();
      logic [31:0] prog [4];
      prog[0] = 32'h0000_0000; prog[1] = 32'hF840_0081;
      prog[2] = 32'hF840_1082; prog[3] = 32'h8B02_0023;
      fetch_en   = 1'b1;
      fetch_addr = 16'd1;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 3);
         tick();
         if (i < 3) begin
            assertCount++; if (run !== 1'b0)         begin failCount++; $display("[TB] FAIL load_run_early[%0d]: got %0b want 0", i, run); end
            assertCount++; if (instr_valid !== 1'b0) begin failCount++; $display("[TB] FAIL load_fetch_ignored[%0d]: got %0b want 0", i, instr_valid); end
            assertCount++; if (instr !== 32'h0)      begin failCount++; $display("[TB] FAIL load_instr_held[%0d]: got %h want 00000000", i, instr); end
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      fetch_en   = 1'b0;
      assertCount++; if (run !== 1'b1)        begin failCount++; $display("[TB] FAIL load_run_rise: got %0b want 1", run); end
      assertCount++; if (load_ready !== 1'b0) begin failCount++; $display("[TB] FAIL load_ready_drop: got %0b want 0", load_ready); end
      assertCount++; if (instr_valid !== 1'b0) begin failCount++; $display("[TB] FAIL load_no_fetch_at_run_edge: got %0b want 0", instr_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] expv [4];
      expv[1] = 32'hF840_0081; expv[2] = 32'hF840_1082; expv[3] = 32'h8B02_0023;
      fetch_en = 1'b1;
      for (int a = 1; a <= 3; a++) begin
         fetch_addr = 16'(a);
         tick();
         assertCount++; if (instr !== expv[a])    begin failCount++; $display("[TB] FAIL b2b_instr[%0d]: got %h want %h", a, instr, expv[a]); end
         assertCount++; if (instr_valid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_valid[%0d]: got %0b want 1", a, instr_valid); end
         assertCount++; if (addr_fault !== 1'b0)  begin failCount++; $display("[TB] FAIL b2b_fault[%0d]: got %0b want 0", a, addr_fault); end
      end
      fetch_en = 1'b0;
   endtask

   task automatic test_stall();
      applyFetch(16'd2);
      assertCount++; if (instr !== 32'hF840_1082) begin failCount++; $display("[TB] FAIL stall_first: got %h want f8401082", instr); end
      fetch_addr = 16'd0;
      for (int c = 0; c < 3; c++) begin
         tick();
         assertCount++; if (instr !== 32'hF840_1082) begin failCount++; $display("[TB] FAIL stall_hold[%0d]: got %h want f8401082", c, instr); end
         assertCount++; if (instr_valid !== 1'b0)    begin failCount++; $display("[TB] FAIL stall_valid[%0d]: got %0b want 0", c, instr_valid); end
      end
      applyFetch(16'd3);
      assertCount++; if (instr !== 32'h8B02_0023) begin failCount++; $display("[TB] FAIL stall_resume: got %h want 8b020023", instr); end
      assertCount++; if (instr_valid !== 1'b1)    begin failCount++; $display("[TB] FAIL stall_resume_valid: got %0b want 1", instr_valid); end
   endtask

   task automatic test_out_of_range();
      logic [15:0] badAddr [2];
      badAddr[0] = 16'd16; badAddr[1] = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         applyFetch(badAddr[k]);
         assertCount++; if (instr !== 32'h0)      begin failCount++; $display("[TB] FAIL oor_instr[%h]: got %h want 00000000", badAddr[k], instr); end
         assertCount++; if (addr_fault !== 1'b1)  begin failCount++; $display("[TB] FAIL oor_fault[%h]: got %0b want 1", badAddr[k], addr_fault); end
         assertCount++; if (instr_valid !== 1'b1) begin failCount++; $display("[TB] FAIL oor_valid[%h]: got %0b want 1", badAddr[k], instr_valid); end
      end
      tick();
      assertCount++; if (addr_fault !== 1'b1) begin failCount++; $display("[TB] FAIL oor_fault_hold: got %0b want 1", addr_fault); end
      applyFetch(16'd15);
      assertCount++; if (addr_fault !== 1'b0) begin failCount++; $display("[TB] FAIL oor_top_in_range: got %0b want 0", addr_fault); end
      applyFetch(16'd16);
      applyFetch(16'd1);
      assertCount++; if (addr_fault !== 1'b0)     begin failCount++; $display("[TB] FAIL oor_clear: got %0b want 0", addr_fault); end
      assertCount++; if (instr !== 32'hF840_0081) begin failCount++; $display("[TB] FAIL oor_recover: got %h want f8400081", instr); end
   endtask

   task automatic test_mid_reset();
      applyReset();
      applyLoad(32'h1111_1111, 1'b0);
      applyLoad(32'h2222_2222, 1'b0);
      assertCount++; if (run !== 1'b0) begin failCount++; $display("[TB] FAIL partial_run: got %0b want 0", run); end
      applyReset();
      assertCount++; if (load_ready !== 1'b1) begin failCount++; $display("[TB] FAIL partial_reset_ready: got %0b want 1", load_ready); end
      applyLoad(32'hAAAA_0000, 1'b0);
      applyLoad(32'hAAAA_0001, 1'b0);
      applyLoad(32'hAAAA_0002, 1'b0);
      applyLoad(32'hAAAA_0003, 1'b1);
      assertCount++; if (run !== 1'b1) begin failCount++; $display("[TB] FAIL reload_run: got %0b want 1", run); end
      applyFetch(16'd0);
      assertCount++; if (instr !== 32'hAAAA_0000) begin failCount++; $display("[TB] FAIL reload_word0: got %h want aaaa0000", instr); end
      applyFetch(16'd3);
      assertCount++; if (instr !== 32'hAAAA_0003) begin failCount++; $display("[TB] FAIL reload_word3: got %h want aaaa0003", instr); end
      applyFetch(16'd20);
      fetch_en = 1'b1;
      fetch_addr = 16'd2;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fetch_en = 1'b0;
      assertCount++; if (run !== 1'b0)         begin failCount++; $display("[TB] FAIL runreset_run: got %0b want 0", run); end
      assertCount++; if (load_ready !== 1'b1)  begin failCount++; $display("[TB] FAIL runreset_ready: got %0b want 1", load_ready); end
      assertCount++; if (instr !== 32'h0)      begin failCount++; $display("[TB] FAIL runreset_instr: got %h want 00000000", instr); end
      assertCount++; if (instr_valid !== 1'b0) begin failCount++; $display("[TB] FAIL runreset_valid: got %0b want 0", instr_valid); end
      assertCount++; if (addr_fault !== 1'b0)  begin failCount++; $display("[TB] FAIL runreset_fault: got %0b want 0", addr_fault); end
   endtask

   task automatic test_full_load();
      applyReset();
      for (int i = 0; i < 16; i++) begin
         applyLoad(32'h1000_0000 + 32'(i), 1'b0);
         if (i == 14) begin
            assertCount++; if (run !== 1'b0) begin failCount++; $display("[TB] FAIL full_run_early: got %0b want 0", run); end
         end
      end
      assertCount++; if (run !== 1'b1)        begin failCount++; $display("[TB] FAIL full_run: got %0b want 1", run); end
      load_valid = 1'b1;
      load_data  = 32'hDEAD_BEEF;
      #1;
      assertCount++; if (load_ready !== 1'b0) begin failCount++; $display("[TB] FAIL full_17th_ready: got %0b want 0", load_ready); end
      tick();
      load_valid = 1'b0;
      applyFetch(16'd0);
      assertCount++; if (instr !== 32'h1000_0000) begin failCount++; $display("[TB] FAIL full_word0: got %h want 10000000", instr); end
      applyFetch(16'd15);
      assertCount++; if (instr !== 32'h1000_000F) begin failCount++; $display("[TB] FAIL full_word15: got %h want 1000000f", instr); end
   endtask

`ifdef IMEM_PARITY_EN
   task automatic test_parity();
      applyReset();
      assertCount++; if (parity_err !== 1'b0) begin failCount++; $display("[TB] FAIL par_reset: got %0b want 0", parity_err); end
      applyLoad(32'h0000_0000, 1'b0);
      applyLoad(32'hF840_0081, 1'b0);
      applyLoad(32'hF840_1082, 1'b0);
      applyLoad(32'h8B02_0023, 1'b1);
      applyFetch(16'd1);
      assertCount++; if (parity_err !== 1'b0) begin failCount++; $display("[TB] FAIL par_clean: got %0b want 0", parity_err); end
      dut.uRam.mem[1] = dut.uRam.mem[1] ^ 33'h1;
      applyFetch(16'd1);
      assertCount++; if (parity_err !== 1'b1)     begin failCount++; $display("[TB] FAIL par_detect: got %0b want 1", parity_err); end
      assertCount++; if (instr_valid !== 1'b1)    begin failCount++; $display("[TB] FAIL par_valid: got %0b want 1", instr_valid); end
      assertCount++; if (instr !== 32'hF840_0080) begin failCount++; $display("[TB] FAIL par_instr: got %h want f8400080", instr); end
      tick();
      assertCount++; if (parity_err !== 1'b1) begin failCount++; $display("[TB] FAIL par_hold: got %0b want 1", parity_err); end
      applyFetch(16'd2);
      assertCount++; if (parity_err !== 1'b0) begin failCount++; $display("[TB] FAIL par_next: got %0b want 0", parity_err); end
      applyFetch(16'd16);
      assertCount++; if (parity_err !== 1'b0) begin failCount++; $display("[TB] FAIL par_oor: got %0b want 0", parity_err); end
   endtask
`endif

   initial begin
      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      fetch_en   = 1'b0;
      fetch_addr = '0;
      tick();
      test_reset();
      test_load();
      test_back_to_back();
      test_stall();
      test_out_of_range();
      test_mid_reset();
      test_full_load();
`ifdef IMEM_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
